// File: rtl/impulse_voice_pkg.sv
// ----------------------------------------------------------------------------
// impulse_voice_pkg
//   Shared types and helpers for the noise-oscillator voice allocator.
//   - ev_kind_t          : event kinds carried on ev_kind
//   - alloc_state_t      : allocator FSM states
//   - VOL_SHIFT / VOL_W  : velocity-to-volume scaling and volume width
//   - velocity_to_volume : maps a 7-bit velocity onto the 17-bit signed volume
// ----------------------------------------------------------------------------
package impulse_voice_pkg;

    typedef enum logic [1:0] {
        NOTE_OFF = 2'd0,
        NOTE_ON  = 2'd1,
        ALL_OFF  = 2'd2,
        RSVD     = 2'd3
    } ev_kind_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        APPLY = 2'd2
    } alloc_state_t;

    localparam int VOL_SHIFT = 8;
    localparam int VOL_W     = 17;

    // {2'b00, velocity, 8'b0}: the top bit stays clear, so the signed volume
    // is never negative; the oscillator supplies polarity.
    function automatic logic [VOL_W-1:0] velocity_to_volume(input logic [6:0] vel);
        return VOL_W'(vel) << VOL_SHIFT;
    endfunction

endpackage

// File: rtl/noise_voice_alloc.sv
// ----------------------------------------------------------------------------
// noise_voice_alloc
//   Voice allocator for a bank of osc_noise oscillators. Accepts note events
//   over a valid/ready handshake, scans the slots one per cycle, then applies
//   the event in a single cycle (retrigger > free slot > steal oldest).
//
// Ports
//   clk, rst       : clock, synchronous active-high reset
//   ev_valid/ready : event handshake (ready is low while an event is in flight)
//   ev_kind        : 0 note-off, 1 note-on, 2 all-off, 3 reserved (no effect)
//   ev_note        : MIDI note number
//   ev_velocity    : MIDI velocity (note-on with 0 acts as note-off)
//   voice_en       : per-slot oscillator enable
//   voice_note     : per-slot note, slot i at [8i+7:8i]
//   voice_volume   : per-slot signed volume, slot i at [17i+16:17i]
//   steal          : one-cycle pulse when a note-on took over an active voice
// ----------------------------------------------------------------------------
module noise_voice_alloc
    import impulse_voice_pkg::*;
#(
    parameter int NUM_VOICES = 4,
    parameter int AGE_W      = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        ev_valid,
    output logic                        ev_ready,
    input  logic [1:0]                  ev_kind,
    input  logic [7:0]                  ev_note,
    input  logic [6:0]                  ev_velocity,
    output logic [NUM_VOICES-1:0]       voice_en,
    output logic [8*NUM_VOICES-1:0]     voice_note,
    output logic [VOL_W*NUM_VOICES-1:0] voice_volume,
    output logic                        steal
);

    localparam int IDX_W = $clog2(NUM_VOICES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

    alloc_state_t     state_q;
    ev_kind_t         kind_q;
    logic [7:0]       evt_note_q;
    logic [6:0]       vel_q;
    logic [IDX_W-1:0] idx_q;

    logic             match_found_q, free_found_q, oldest_found_q;
    logic [IDX_W-1:0] match_idx_q, free_idx_q, oldest_idx_q;
    logic [AGE_W-1:0] oldest_age_q;

    logic             en_q   [NUM_VOICES];
    logic [7:0]       vnote_q[NUM_VOICES];
    logic [VOL_W-1:0] vol_q  [NUM_VOICES];
    logic [AGE_W-1:0] age_q  [NUM_VOICES];
    logic             steal_q;

    // Slot under examination during SCAN.
    logic             cur_en;
    logic [7:0]       cur_note;
    logic [AGE_W-1:0] cur_age;

    // Decisions made in APPLY from the scan results.
    logic             note_on_eff, note_off_eff, take_steal;
    logic [IDX_W-1:0] tgt_idx;

    assign ev_ready = (state_q == IDLE) && !rst;
    assign steal    = steal_q;

    // NOTE: every always_comb output gets a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    always_comb begin
        cur_en       = en_q[idx_q];
        cur_note     = vnote_q[idx_q];
        cur_age      = age_q[idx_q];
        note_on_eff  = (kind_q == NOTE_ON) && (vel_q != 7'd0);
        note_off_eff = (kind_q == NOTE_OFF) || ((kind_q == NOTE_ON) && (vel_q == 7'd0));
        take_steal   = 1'b0;
        tgt_idx      = oldest_idx_q;
        if (match_found_q) begin
            tgt_idx = match_idx_q;
        end else if (free_found_q) begin
            tgt_idx = free_idx_q;
        end else begin
            // No free slot means every slot is active, so an oldest exists.
            take_steal = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values from before the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            kind_q         <= NOTE_OFF;
            evt_note_q     <= '0;
            vel_q          <= '0;
            idx_q          <= '0;
            match_found_q  <= 1'b0;
            free_found_q   <= 1'b0;
            oldest_found_q <= 1'b0;
            match_idx_q    <= '0;
            free_idx_q     <= '0;
            oldest_idx_q   <= '0;
            oldest_age_q   <= '0;
            steal_q        <= 1'b0;
            // NOTE: the voice arrays are a handful of flops driving outputs,
            // not a RAM, so they are reset like any other register.
            for (int i = 0; i < NUM_VOICES; i++) begin
                en_q[i]    <= 1'b0;
                vnote_q[i] <= '0;
                vol_q[i]   <= '0;
                age_q[i]   <= '0;
            end
        end else begin
            steal_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (ev_valid) begin
                        kind_q         <= ev_kind_t'(ev_kind);
                        evt_note_q     <= ev_note;
                        vel_q          <= ev_velocity;
                        match_found_q  <= 1'b0;
                        free_found_q   <= 1'b0;
                        oldest_found_q <= 1'b0;
                        match_idx_q    <= '0;
                        free_idx_q     <= '0;
                        oldest_idx_q   <= '0;
                        oldest_age_q   <= '0;
                        idx_q          <= '0;
                        state_q        <= SCAN;
                    end
                end

                SCAN: begin
                    // Each record keeps its first hit, so the lowest index wins.
                    if (cur_en && (cur_note == evt_note_q) && !match_found_q) begin
                        match_found_q <= 1'b1;
                        match_idx_q   <= idx_q;
                    end
                    if (!cur_en && !free_found_q) begin
                        free_found_q <= 1'b1;
                        free_idx_q   <= idx_q;
                    end
                    // Strict compare: an equal age does not displace a lower index.
                    if (cur_en && (!oldest_found_q || (cur_age > oldest_age_q))) begin
                        oldest_found_q <= 1'b1;
                        oldest_idx_q   <= idx_q;
                        oldest_age_q   <= cur_age;
                    end
                    if (idx_q == LAST_IDX) begin
                        state_q <= APPLY;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end

                APPLY: begin
                    for (int i = 0; i < NUM_VOICES; i++) begin
                        if (kind_q == ALL_OFF) begin
                            en_q[i]  <= 1'b0;
                            vol_q[i] <= '0;
                            age_q[i] <= '0;
                        end else if (note_on_eff) begin
                            if (IDX_W'(i) == tgt_idx) begin
                                en_q[i]    <= 1'b1;
                                vnote_q[i] <= evt_note_q;
                                vol_q[i]   <= velocity_to_volume(vel_q);
                                age_q[i]   <= '0;
                            end else if (en_q[i] && !(&age_q[i])) begin
                                age_q[i] <= age_q[i] + 1'b1;
                            end
                        end else if (note_off_eff && match_found_q &&
                                     (IDX_W'(i) == match_idx_q)) begin
                            en_q[i]  <= 1'b0;
                            vol_q[i] <= '0;
                            age_q[i] <= '0;
                        end
                    end
                    steal_q <= note_on_eff && take_steal;
                    state_q <= IDLE;
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    for (genvar g = 0; g < NUM_VOICES; g++) begin : g_flatten
        assign voice_en[g]                  = en_q[g];
        assign voice_note[8*g +: 8]         = vnote_q[g];
        assign voice_volume[VOL_W*g +: VOL_W] = vol_q[g];
    end

endmodule

// File: tb/tb_noise_voice_alloc.sv
// ----------------------------------------------------------------------------
// tb_noise_voice_alloc
//   Directed bench for noise_voice_alloc with NUM_VOICES = 4: reset, reset
//   during a scan, a table of events with hand-computed slot contents, and
//   back-to-back acceptance with ev_valid held high.
// ----------------------------------------------------------------------------
module tb_noise_voice_alloc;

    localparam int NV = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          ev_valid;
    logic          ev_ready;
    logic [1:0]    ev_kind;
    logic [7:0]    ev_note;
    logic [6:0]    ev_velocity;
    logic [NV-1:0] voice_en;
    logic [8*NV-1:0]  voice_note;
    logic [17*NV-1:0] voice_volume;
    logic          steal;

    int n_checks = 0;
    int n_fail   = 0;

    noise_voice_alloc #(.NUM_VOICES(NV), .AGE_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .ev_valid    (ev_valid),
        .ev_ready    (ev_ready),
        .ev_kind     (ev_kind),
        .ev_note     (ev_note),
        .ev_velocity (ev_velocity),
        .voice_en    (voice_en),
        .voice_note  (voice_note),
        .voice_volume(voice_volume),
        .steal       (steal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  kind;
        logic [7:0]  note;
        logic [6:0]  vel;
        logic [3:0]  en;
        logic [31:0] notes;
        logic [67:0] vols;
        logic        stl;
    } vec_t;

    vec_t vecs[$];
    logic [3:0]  prev_en;
    logic [67:0] prev_vols;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] k, input int n, input int v, input logic [3:0] en,
                                input int n0, input int n1, input int n2, input int n3,
                                input int v0, input int v1, input int v2, input int v3,
                                input logic s);
        vec_t r;
        r.kind  = k;
        r.note  = 8'(n);
        r.vel   = 7'(v);
        r.en    = en;
        r.notes = {8'(n3), 8'(n2), 8'(n1), 8'(n0)};
        r.vols  = {17'(v3), 17'(v2), 17'(v1), 17'(v0)};
        r.stl   = s;
        return r;
    endfunction

    // Called just after a negedge; returns just after a negedge.
    task automatic run_vec(input int id, input vec_t v);
        int n;
        ev_kind     = v.kind;
        ev_note     = v.note;
        ev_velocity = v.vel;
        ev_valid    = 1'b1;
        n = 0;
        while (!ev_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check($sformatf("vec%0d accept timeout", id), 1'b0, 1'b1);
        @(posedge clk);                 // E0
        @(negedge clk);
        ev_valid = 1'b0;
        check($sformatf("vec%0d ready low E0", id), ev_ready, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check($sformatf("vec%0d ready low E%0d", id, k), ev_ready, 1'b0);
        end
        check($sformatf("vec%0d en held", id), voice_en, prev_en);
        check($sformatf("vec%0d vol held", id), voice_volume, prev_vols);
        @(negedge clk);                 // after E5
        check($sformatf("vec%0d en", id), voice_en, v.en);
        check($sformatf("vec%0d note", id), voice_note, v.notes);
        check($sformatf("vec%0d vol", id), voice_volume, v.vols);
        check($sformatf("vec%0d steal", id), steal, v.stl);
        check($sformatf("vec%0d ready back", id), ev_ready, 1'b1);
        @(negedge clk);
        check($sformatf("vec%0d steal clear", id), steal, 1'b0);
        prev_en   = v.en;
        prev_vols = v.vols;
    endtask

    initial begin
        int acc[3];
        int k;
        int cyc;
        logic [7:0] bb_note[3];

        rst = 1'b1; ev_valid = 1'b0; ev_kind = 2'd0; ev_note = 8'd0; ev_velocity = 7'd0;
        prev_en = '0; prev_vols = '0;

        // Reset state.
        repeat (3) @(negedge clk);
        check("ready low in reset", ev_ready, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check("reset en", voice_en, 4'b0);
        check("reset note", voice_note, 32'b0);
        check("reset vol", voice_volume, 68'b0);
        check("reset steal", steal, 1'b0);
        check("reset ready", ev_ready, 1'b1);

        // Reset during SCAN drops the event.
        ev_kind = 2'd1; ev_note = 8'd60; ev_velocity = 7'd100; ev_valid = 1'b1;
        @(posedge clk);                 // accepted
        @(negedge clk);
        ev_valid = 1'b0;
        @(negedge clk);                 // mid-scan
        rst = 1'b1;
        @(negedge clk);
        check("ready low mid reset", ev_ready, 1'b0);
        rst = 1'b0;
        repeat (7) @(negedge clk);
        check("dropped en", voice_en, 4'b0);
        check("dropped note", voice_note, 32'b0);
        check("dropped vol", voice_volume, 68'b0);
        check("dropped ready", ev_ready, 1'b1);

        // Directed table: kind, note, vel, en, notes s0..s3, vols s0..s3, steal.
        vecs.push_back(mk(2'd1, 60, 100, 4'b0001, 60, 0, 0, 0, 25600, 0, 0, 0, 1'b0));
        vecs.push_back(mk(2'd1, 62, 100, 4'b0011, 60, 62, 0, 0, 25600, 25600, 0, 0, 1'b0));
        vecs.push_back(mk(2'd1, 64, 100, 4'b0111, 60, 62, 64, 0, 25600, 25600, 25600, 0, 1'b0));
        vecs.push_back(mk(2'd1, 65, 100, 4'b1111, 60, 62, 64, 65, 25600, 25600, 25600, 25600, 1'b0));
        vecs.push_back(mk(2'd1, 67, 127, 4'b1111, 67, 62, 64, 65, 32512, 25600, 25600, 25600, 1'b1));
        vecs.push_back(mk(2'd1, 69, 100, 4'b1111, 67, 69, 64, 65, 32512, 25600, 25600, 25600, 1'b1));
        vecs.push_back(mk(2'd2, 0, 0, 4'b0000, 67, 69, 64, 65, 0, 0, 0, 0, 1'b0));
        vecs.push_back(mk(2'd1, 60, 100, 4'b0001, 60, 69, 64, 65, 25600, 0, 0, 0, 1'b0));
        vecs.push_back(mk(2'd1, 62, 100, 4'b0011, 60, 62, 64, 65, 25600, 25600, 0, 0, 1'b0));
        vecs.push_back(mk(2'd1, 64, 100, 4'b0111, 60, 62, 64, 65, 25600, 25600, 25600, 0, 1'b0));
        vecs.push_back(mk(2'd1, 62, 50, 4'b0111, 60, 62, 64, 65, 25600, 12800, 25600, 0, 1'b0));
        vecs.push_back(mk(2'd0, 62, 0, 4'b0101, 60, 62, 64, 65, 25600, 0, 25600, 0, 1'b0));
        vecs.push_back(mk(2'd0, 99, 0, 4'b0101, 60, 62, 64, 65, 25600, 0, 25600, 0, 1'b0));
        vecs.push_back(mk(2'd1, 71, 10, 4'b0111, 60, 71, 64, 65, 25600, 2560, 25600, 0, 1'b0));
        vecs.push_back(mk(2'd1, 64, 0, 4'b0011, 60, 71, 64, 65, 25600, 2560, 0, 0, 1'b0));
        vecs.push_back(mk(2'd3, 60, 5, 4'b0011, 60, 71, 64, 65, 25600, 2560, 0, 0, 1'b0));
        vecs.push_back(mk(2'd2, 0, 0, 4'b0000, 60, 71, 64, 65, 0, 0, 0, 0, 1'b0));

        foreach (vecs[i]) run_vec(i, vecs[i]);

        // Back-to-back: ev_valid held high across three note-ons.
        bb_note[0] = 8'd80; bb_note[1] = 8'd81; bb_note[2] = 8'd82;
        ev_kind = 2'd1; ev_velocity = 7'd20; ev_note = bb_note[0]; ev_valid = 1'b1;
        k = 0; cyc = 0;
        while (k < 3 && cyc < 100) begin
            if (ev_ready) begin
                acc[k] = cyc;
                k++;
                @(posedge clk);
                @(negedge clk);
                cyc++;
                if (k < 3) ev_note = bb_note[k];
                else ev_valid = 1'b0;
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        check("b2b accepted count", 32'(k), 32'd3);
        if (k == 3) begin
            check("b2b spacing 0-1", 32'(acc[1] - acc[0]), 32'd6);
            check("b2b spacing 1-2", 32'(acc[2] - acc[1]), 32'd6);
        end
        repeat (5) @(negedge clk);
        check("b2b en", voice_en, 4'b0111);
        check("b2b note", voice_note, {8'd65, 8'd82, 8'd81, 8'd80});
        check("b2b vol", voice_volume, {17'd0, 17'd5120, 17'd5120, 17'd5120});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/noise_voice_alloc.md
# noise_voice_alloc

Voice allocator and scheduler for a bank of `osc_noise` oscillators. It accepts MIDI-style note events over a valid/ready handshake and assigns each event to one of `NUM_VOICES` oscillator slots. It drives each slot's `en`, `note` and `volume` inputs, and steals the oldest voice when all slots are busy. It sits between the MIDI decoder and the noise oscillator bank, ahead of the mixer.

## Interface
Parameters:
- `NUM_VOICES`, default 4: number of oscillator slots managed; must be 2..16.
- `AGE_W`, default 8: width of the per-voice saturating age counter.

Ports:
- `clk`  in  1: single clock.
- `rst`  in  1: reset, synchronous and active-high.
- `ev_valid`  in  1: event present.
- `ev_ready`  out  1: allocator can accept an event.
- `ev_kind`  in  2: 0 = note-off, 1 = note-on, 2 = all-off, 3 = reserved (accepted, no effect).
- `ev_note`  in  8: MIDI note number, 0..127.
- `ev_velocity`  in  7: MIDI velocity.
- `voice_en`  out  NUM_VOICES: per-slot oscillator enable.
- `voice_note`  out  8*NUM_VOICES: per-slot note; slot i is bits [8i+7:8i].
- `voice_volume`  out  17*NUM_VOICES: per-slot signed volume; slot i is bits [17i+16:17i].
- `steal`  out  1: one-cycle pulse when a note-on stole an active voice.

## Operation
- FSM states: IDLE, SCAN, APPLY.
- IDLE:
  - `ev_ready` = 1.
  - On `ev_valid && ev_ready`: latch kind, note and velocity; clear the scan results; idx ← 0; go to SCAN.
- SCAN:
  - Examines one slot per cycle, idx 0..NUM_VOICES-1; goes to APPLY after the last slot.
  - Per slot, it records three things, each favouring the lowest index:
    - the first active slot whose note equals the latched note (match);
    - the first inactive slot (free);
    - the active slot with the greatest age (oldest; on equal ages the lowest index wins).
- APPLY (one cycle), then back to IDLE.
- Note-on with velocity 0 is treated as note-off.
- Note-on selects its target slot in priority order:
  1. The match slot, if any: a retrigger.
  2. Otherwise the free slot, if any.
  3. Otherwise the oldest slot: `steal` ← 1.
- Note-on then updates the target slot:
  - en ← 1, note ← latched note, volume ← {2'b00, velocity, 8'b0}, giving 0..32512.
  - Target age ← 0.
  - Every other active slot's age ← min(age+1, 2^AGE_W−1).
- Note-off:
  - If a match slot exists: en ← 0, volume ← 0, age ← 0. Note holds its last value.
  - If no match exists: no change.
- All-off: every slot gets en ← 0, volume ← 0, age ← 0.
- Duplicate note-ons never occupy two slots, because a repeated note always retriggers.
- Volume is always non-negative. The oscillator supplies polarity.

## Timing
- Handshake completes at the clock edge where `ev_valid && ev_ready`. Call that edge E0.
- SCAN occupies the edges E1..E_N, where N = NUM_VOICES.
- APPLY occupies edge E_{N+1}. All voice outputs and `steal` update at that edge.
- `ev_ready` is low from after E0 until after E_{N+1}.
- Fixed latency: N+1 cycles from acceptance to updated outputs. Throughput: one event per N+2 cycles.
- `ev_ready` is combinational: (state == IDLE) && !rst.
- `steal` is high for exactly the one cycle after E_{N+1}; otherwise it is 0.
- Voice state is frozen during SCAN, so scan results are consistent.
- Reset values, on any edge with `rst` = 1 and in any state:
  - state IDLE;
  - `voice_en`, `voice_note`, `voice_volume`, all ages and `steal` all 0;
  - any in-flight event is discarded.
- Upstream may hold `ev_valid` high through reset; the event is accepted at the first non-reset edge.
- Ages saturate and never wrap.

## Structure
- Package `impulse_voice_pkg` holds:
  - the `ev_kind_t` enum (NOTE_OFF, NOTE_ON, ALL_OFF, RSVD);
  - the `alloc_state_t` enum (IDLE, SCAN, APPLY);
  - `VOL_SHIFT` = 8;
  - the function `velocity_to_volume`.
- Single module; no sub-module. A generate loop instantiating `osc_noise` belongs to the enclosing voice-bank wrapper, not to this block.

## Test plan
All scenarios use NUM_VOICES = 4.
- **Reset:** after reset, all outputs are 0 and `ev_ready` = 1. Assert `rst` in the middle of SCAN → the event is dropped and outputs stay 0.
- **Fill:** note-on 60/100, 62/100, 64/100, 65/100 → slots 0..3 enabled with notes 60, 62, 64, 65 and volume 25600 each. Each update appears 5 cycles after acceptance, and `ev_ready` is low for 5 cycles after each accept.
- **Steal:** a fifth note-on 67/127 → slot 0 gets note 67 and volume 32512, with a one-cycle `steal` pulse. A sixth note-on 69 → steals slot 1.
- **Retrigger and note-off:** note-on 62/50 while 62 is active in slot 1 → slot 1 volume 12800, no steal, no new slot. Note-off 62 → slot 1 en = 0. Note-off 99 (inactive) → no change.
- **Velocity 0 and all-off:** note-on 64/0 → behaves as note-off for slot 2. All-off → `voice_en` = 4'b0000 and all volumes 0.
- **Back-to-back:** `ev_valid` held high with 3 queued events → one accept every 6 cycles with no event lost. A kind = 3 event is accepted with no output change.
